// File: rtl/scfifo_stream_drain.sv
// scfifo_stream_drain: read-side stage for a show-ahead scfifo. It pops the
// FIFO into a 2-entry skid buffer and presents a registered valid/ready
// stream. A flush mode discards buffered and queued words. Saturating
// counters track accepted beats and stalled cycles.
module scfifo_stream_drain #(
  parameter int WIDTH     = 1,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     fifo_q,
  input  logic                 fifo_empty,
  output logic                 fifo_rdreq,
  input  logic                 flush,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  input  logic                 out_ready,
  output logic                 flush_busy,
  output logic [CNT_WIDTH-1:0] beat_count,
  output logic [CNT_WIDTH-1:0] stall_count
);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  state_t               state_r, state_s;
  logic [1:0]           cnt_r, cnt_s;
  logic [WIDTH-1:0]     buf0_r, buf0_s;
  logic [WIDTH-1:0]     buf1_r, buf1_s;
  logic                 out_valid_r, out_valid_s;
  logic                 pop_s;
  logic                 take_s;
  logic                 stall_s;
  logic [1:0]           slot_s;
  logic [CNT_WIDTH-1:0] beat_count_r;
  logic [CNT_WIDTH-1:0] stall_count_r;

  // Pop request: registered state and fifo_empty only, never out_ready, so no
  // combinational path runs from the downstream handshake back to the FIFO.
  always_comb begin
    pop_s = 1'b0;
    if (reset) begin
      pop_s = 1'b0;
    end else if (fifo_empty) begin
      pop_s = 1'b0;
    end else if (state_r == ST_FLUSH) begin
      pop_s = 1'b1;
    end else begin
      pop_s = (cnt_r != 2'd2);
    end
  end

  assign take_s  = out_valid_r & out_ready;
  assign stall_s = out_valid_r & ~out_ready;

  // Next-state, occupancy and buffer contents; out_valid is precomputed here
  // so the output itself comes straight from a flop.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    buf0_s  = buf0_r;
    buf1_s  = buf1_r;
    slot_s  = cnt_r - {1'b0, take_s};
    case (state_r)
      ST_RUN: begin
        if (flush) begin
          // A handshake in this cycle still counts; everything else is dropped.
          state_s = ST_FLUSH;
          cnt_s   = 2'd0;
          buf0_s  = {WIDTH{1'b0}};
          buf1_s  = {WIDTH{1'b0}};
        end else begin
          cnt_s = cnt_r + {1'b0, pop_s} - {1'b0, take_s};
          if (take_s) begin
            buf0_s = buf1_r;
          end else begin
            buf0_s = buf0_r;
          end
          if (pop_s) begin
            if (slot_s == 2'd0) begin
              buf0_s = fifo_q;
            end else begin
              buf1_s = fifo_q;
            end
          end else begin
            buf1_s = buf1_r;
          end
        end
      end
      ST_FLUSH: begin
        // Popped words are simply not stored while flushing.
        if (!flush && fifo_empty) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_FLUSH;
        end
      end
      default: begin
        state_s = ST_RUN;
        cnt_s   = 2'd0;
      end
    endcase
    out_valid_s = (state_s == ST_RUN) && (cnt_s != 2'd0);
  end

  // State, occupancy, buffer and valid registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= ST_RUN;
      cnt_r       <= 2'd0;
      buf0_r      <= {WIDTH{1'b0}};
      buf1_r      <= {WIDTH{1'b0}};
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      buf0_r      <= buf0_s;
      buf1_r      <= buf1_s;
      out_valid_r <= out_valid_s;
    end
  end

  // Saturating statistics; flush leaves them untouched.
  always_ff @(posedge clock) begin
    if (reset) begin
      beat_count_r  <= {CNT_WIDTH{1'b0}};
      stall_count_r <= {CNT_WIDTH{1'b0}};
    end else begin
      if (take_s && !(&beat_count_r)) begin
        beat_count_r <= beat_count_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end else begin
        beat_count_r <= beat_count_r;
      end
      if (stall_s && !(&stall_count_r)) begin
        stall_count_r <= stall_count_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end else begin
        stall_count_r <= stall_count_r;
      end
    end
  end

  assign fifo_rdreq  = pop_s;
  assign out_valid   = out_valid_r;
  assign out_data    = buf0_r;
  assign flush_busy  = (state_r == ST_FLUSH);
  assign beat_count  = beat_count_r;
  assign stall_count = stall_count_r;

endmodule
